// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    localparam int unsigned DATA_W          = 32;
    localparam int unsigned ADDR_W          = 32;
    localparam int unsigned STRB_W          = DATA_W / 8;
    localparam int unsigned BYTE_OFF_W      = 2;
    localparam int unsigned CNT_W           = 4;
    localparam int unsigned DEPTH_WORDS_DEF = 256;
    localparam int unsigned LATENCY_DEF     = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Response payload held stable for the core while rsp_valid is high.
    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    // A request is rejected when it is not word aligned or falls past the last word.
    function automatic logic addr_is_err(input logic [ADDR_W-1:0] addr,
                                         input int unsigned      depth);
        logic misaligned;
        logic out_of_range;
        misaligned   = (addr[BYTE_OFF_W-1:0] != '0);
        out_of_range = (ADDR_W'(addr[ADDR_W-1:BYTE_OFF_W]) >= ADDR_W'(depth));
        return misaligned | out_of_range;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word storage: one synchronous byte-enabled write port, one registered read port.
// Contents are deliberately never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [STRB_W-1:0] wbe,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < int'(STRB_W); b++) begin
                if (wbe[b]) begin
                    mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    // Read word captured on the enable edge and held until the next read.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store, answers after LATENCY cycles.
// Optional macro DATA_MEM_RESP_BYTE_STRB_EN enables per-byte store strobes;
// without it every accepted store writes the full word.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int unsigned LATENCY     = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, cnt_nx;
    logic              req_ready_nx;
    logic              rsp_valid_nx;
    rsp_t              rsp_q, rsp_nx;
    logic              pend_err;
    logic              pend_rd;
    logic              accept_c;
    logic              req_err_c;
    logic [STRB_W-1:0] wbe_c;
    logic [IDX_W-1:0]  idx_c;
    logic [DATA_W-1:0] arr_rdata;

    assign accept_c  = (state == ST_IDLE) && req_valid && !rst;
    assign req_err_c = addr_is_err(req_addr, DEPTH_WORDS);
    assign idx_c     = req_addr[IDX_W+BYTE_OFF_W-1:BYTE_OFF_W];

`ifdef DATA_MEM_RESP_BYTE_STRB_EN
    assign wbe_c = req_wstrb;
`else
    logic unused_wstrb;
    assign unused_wstrb = ^req_wstrb;
    assign wbe_c        = '1;
`endif

    // Storage; writes and reads both happen on the acceptance edge.
    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (accept_c && req_we && !req_err_c),
        .wbe   (wbe_c),
        .waddr (idx_c),
        .wdata (req_wdata),
        .re    (accept_c && !req_we && !req_err_c),
        .raddr (idx_c),
        .rdata (arr_rdata)
    );

    // Next-state, counter and registered-output values.
    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        rsp_nx       = rsp_q;
        req_ready_nx = 1'b0;
        rsp_valid_nx = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = CNT_W'(LATENCY - 1);
                end
            end
            ST_WAIT: begin
                if (cnt == '0) begin
                    state_nx = ST_RESP;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase

        req_ready_nx = (state_nx == ST_IDLE);
        rsp_valid_nx = (state_nx == ST_RESP);

        if (state_nx != ST_RESP) begin
            rsp_nx = '0;
        end else if (state != ST_RESP) begin
            rsp_nx.err   = pend_err;
            rsp_nx.rdata = pend_rd ? arr_rdata : '0;
        end
    end

    // State, counter and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_q     <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            req_ready <= req_ready_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_q     <= rsp_nx;
        end
    end

    // Remember how the accepted request must be answered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_err <= 1'b0;
            pend_rd  <= 1'b0;
        end else if (accept_c) begin
            pend_err <= req_err_c;
            pend_rd  <= !req_we && !req_err_c;
        end
    end

    assign rsp_rdata = rsp_q.rdata;
    assign rsp_err   = rsp_q.err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, randomized traffic, and a
// second LATENCY=1 instance for back-to-back timing.
module tb_data_mem_responder;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
    localparam int unsigned B_LAT = 1;

`ifdef DATA_MEM_RESP_BYTE_STRB_EN
    localparam logic [31:0] EXP_PART = 32'hDEAD3344;
`else
    localparam logic [31:0] EXP_PART = 32'h11223344;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0]  req_wstrb = '0;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        b_req_valid = 1'b0, b_req_we = 1'b0, b_rsp_ready = 1'b0;
    logic [31:0] b_req_addr = '0, b_req_wdata = '0;
    logic [3:0]  b_req_wstrb = 4'hF;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(B_LAT)) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_wstrb(b_req_wstrb),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    int errs   = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    bit [31:0] m_mem [DEPTH];
    bit        m_busy = 1'b0;
    int        m_age  = 0;
    bit [31:0] m_rd   = '0;
    bit        m_err  = 1'b0;
    bit        mdl_e;
    int        mdl_idx;
    bit [3:0]  mdl_st;
    // inputs as sampled by the most recent rising edge
    bit        s_rst = 1'b1, s_valid = 1'b0, s_we = 1'b0, s_rr = 1'b0;
    bit [31:0] s_addr = '0, s_wdata = '0;
    bit [3:0]  s_strb = '0;

    function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] nw, input bit [3:0] st);
        bit [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (st[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Apply the effect of the last edge, then compare every output.
    always @(negedge clk) begin
        if (s_rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (s_valid) begin
                mdl_e   = (s_addr[1:0] != 2'b00) || ((s_addr >> 2) >= 32'(DEPTH));
                mdl_idx = int'(s_addr[9:2]);
                m_err   = mdl_e;
                m_rd    = '0;
`ifdef DATA_MEM_RESP_BYTE_STRB_EN
                mdl_st = s_strb;
`else
                mdl_st = 4'hF;
`endif
                if (!mdl_e) begin
                    if (s_we) m_mem[mdl_idx] = merge(m_mem[mdl_idx], s_wdata, mdl_st);
                    else      m_rd = m_mem[mdl_idx];
                end
                m_busy = 1'b1;
                m_age  = 0;
            end
        end else if (m_age >= int'(LAT) && s_rr) begin
            m_busy = 1'b0;
        end else begin
            m_age++;
        end
        if (rst) m_busy = 1'b0;

        chk("m_req_ready", 32'(req_ready), 32'(!m_busy));
        chk("m_rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= int'(LAT)));
        if (m_busy && m_age >= int'(LAT)) begin
            chk("m_rsp_rdata", rsp_rdata, m_rd);
            chk("m_rsp_err", 32'(rsp_err), 32'(m_err));
        end else if (rst) begin
            chk("m_rst_rdata", rsp_rdata, 32'h0);
            chk("m_rst_err", 32'(rsp_err), 32'h0);
        end

        s_rst = rst; s_valid = req_valid; s_we = req_we; s_rr = rsp_ready;
        s_addr = req_addr; s_wdata = req_wdata; s_strb = req_wstrb;
    end

    // ---------------- directed transaction on the main instance ----------------
    task automatic transact(input string nm, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb, input int hold,
                            input logic [31:0] exp_rd, input bit exp_err);
        int n;
        int lat;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (!req_ready) begin
            chk({nm, "_accept"}, 32'(req_ready), 32'h1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        // noise while busy; must be ignored
        req_valid = 1'b1; req_we = 1'($urandom_range(0, 1));
        req_addr = $urandom & 32'h3FF; req_wdata = $urandom; req_wstrb = 4'($urandom_range(0, 15));
        lat = 0;
        @(negedge clk);
        while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
        chk({nm, "_latency"}, 32'(lat), 32'(LAT));
        chk({nm, "_rdata"}, rsp_rdata, exp_rd);
        chk({nm, "_err"}, 32'(rsp_err), 32'(exp_err));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({nm, "_hold_valid"}, 32'(rsp_valid), 32'h1);
            chk({nm, "_hold_rdata"}, rsp_rdata, exp_rd);
            chk({nm, "_hold_err"}, 32'(rsp_err), 32'(exp_err));
            chk({nm, "_hold_ready"}, 32'(req_ready), 32'h0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({nm, "_ready_after"}, 32'(req_ready), 32'h1);
        chk({nm, "_valid_after"}, 32'(rsp_valid), 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel <= 6)      return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
        else if (sel == 7) return {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
        else if (sel == 8) return $urandom | 32'h0000_0400;
        else               return ($urandom_range(0, 1) != 0) ? 32'h0000_03FC : 32'h0000_0400;
    endfunction

    // ---------------- LATENCY=1 back-to-back monitor ----------------
    bit b_run  = 1'b0;
    int b_viol = 0;
    always @(negedge clk) begin
        if (b_run && b_req_ready && b_rsp_valid) b_viol++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int lat;
        int acc [8];

        // reset values
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        // give every word a defined value
        for (int i = 0; i < int'(DEPTH); i++)
            transact("preload", 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 32'h0, 1'b0);

        transact("st_beef",  1'b1, 32'h10,  32'hDEADBEEF, 4'hF, 0, 32'h0, 1'b0);
        transact("ld_beef",  1'b0, 32'h10,  32'h0,        4'h0, 0, 32'hDEADBEEF, 1'b0);
        transact("st_part",  1'b1, 32'h10,  32'h11223344, 4'h3, 0, 32'h0, 1'b0);
        transact("ld_part",  1'b0, 32'h10,  32'h0,        4'h0, 0, EXP_PART, 1'b0);
        transact("ld_mis",   1'b0, 32'h12,  32'h0,        4'h0, 0, 32'h0, 1'b1);
        transact("ld_oor",   1'b0, 32'h400, 32'h0,        4'h0, 0, 32'h0, 1'b1);
        transact("st_mis",   1'b1, 32'h402, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
        transact("ld_keep",  1'b0, 32'h10,  32'h0,        4'h0, 0, EXP_PART, 1'b0);
        transact("st_w0",    1'b1, 32'h0,   32'h0BADF00D, 4'hF, 0, 32'h0, 1'b0);
        transact("st_oor",   1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 1'b1);
        transact("ld_w0",    1'b0, 32'h0,   32'h0,        4'h0, 0, 32'h0BADF00D, 1'b0);
        transact("st_last",  1'b1, 32'h3FC, 32'h5A5A0FF0, 4'hF, 0, 32'h0, 1'b0);
        transact("ld_last",  1'b0, 32'h3FC, 32'h0,        4'h0, 0, 32'h5A5A0FF0, 1'b0);
        transact("ld_hold",  1'b0, 32'h10,  32'h0,        4'h0, 5, EXP_PART, 1'b0);

        // reset while waiting after an accepted store
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'hA5A5A5A5; req_wstrb = 4'hF;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        chk("rstw_accept", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_req_ready", 32'(req_ready), 32'h1);
        chk("rstw_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rstw_rsp_rdata", rsp_rdata, 32'h0);
        chk("rstw_rsp_err", 32'(rsp_err), 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rstw_no_rsp", 32'(rsp_valid), 32'h0);
        end
        transact("ld_a5", 1'b0, 32'h20, 32'h0, 4'h0, 0, 32'hA5A5A5A5, 1'b0);

        // randomized traffic, checked by the model every cycle
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            req_valid = 1'($urandom_range(0, 1));
            req_we    = 1'($urandom_range(0, 1));
            req_addr  = rand_addr();
            req_wdata = $urandom;
            req_wstrb = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 rsp_ready = 1'b0;

        // LATENCY=1: back-to-back with req_valid and rsp_ready held high
        b_run = 1'b1;
        @(posedge clk); #1;
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        for (int op = 0; op < 8; op++) begin
            b_req_we    = (op < 4);
            b_req_addr  = 32'((op % 4) * 4);
            b_req_wdata = 32'hC0DE0000 + 32'(op % 4);
            n = 0;
            @(negedge clk);
            while (!b_req_ready && n < 20) begin @(negedge clk); n++; end
            chk("b_accept", 32'(b_req_ready), 32'h1);
            if (!b_req_ready) break;
            acc[op] = cyc;
            @(posedge clk); #1;
            if (op == 7) b_req_valid = 1'b0;
            lat = 0;
            @(negedge clk);
            while (!b_rsp_valid && lat < 20) begin @(negedge clk); lat++; end
            chk("b_latency", 32'(lat), 32'(B_LAT));
            chk("b_rdata", b_rsp_rdata, (op < 4) ? 32'h0 : 32'hC0DE0000 + 32'(op % 4));
            chk("b_err", 32'(b_rsp_err), 32'h0);
            // one valid cycle, one idle cycle, then the latency
            if (op > 0) chk("b_interval", 32'(acc[op] - acc[op-1]), 32'(B_LAT + 2));
        end
        repeat (4) @(negedge clk);
        b_run = 1'b0;
        chk("b_overlap", 32'(b_viol), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
